// File: rtl/mul_pkg.sv
// Shared types and helpers for the Booth multiplier family.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One recoded radix-4 Booth digit: magnitude select plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Number of radix-4 digits needed to cover a WIDTH-bit operand
  // extended by two bits, which keeps signed and unsigned products exact.
  function automatic int iter_for(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: three overlapping multiplier bits to {0, +-1, +-2}.
module booth_digit_encoder
  import mul_pkg::*;
(
  input  logic [2:0]   bits,
  output booth_digit_t digit
);

  // Map {y[2i+1], y[2i], y[2i-1]}; zero digits never set neg.
  always_comb begin
    digit = '0;
    case (bits)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100: begin
        digit.two = 1'b1;
        digit.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        digit.one = 1'b1;
        digit.neg = 1'b1;
      end
      default: digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ITER = iter_for(WIDTH);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     mcand;
  logic [EW:0]       mult;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     count;
  logic [2*WIDTH-1:0] p_reg;

  logic              accept;
  logic              last;
  logic              zero_op;
  logic [EW-1:0]     x_ext;
  logic [EW-1:0]     y_ext;
  booth_digit_t      digit;
  logic [AW-1:0]     addend_mag;
  logic [AW-1:0]     addend;
  logic [AW-1:0]     acc_sum;

  // The lowest three bits of the shifting multiplier register are the current digit.
  booth_digit_encoder u_enc (
    .bits  (mult[2:0]),
    .digit (digit)
  );

  // Operand extension and the single add that folds in +-x / +-2x.
  always_comb begin
    x_ext      = {{2{in_signed & x[WIDTH-1]}}, x};
    y_ext      = {{2{in_signed & y[WIDTH-1]}}, y};
    zero_op    = (x == '0) || (y == '0);
    addend_mag = '0;
    if (digit.two)
      addend_mag = {mcand[AW-2:0], 1'b0};
    else if (digit.one)
      addend_mag = mcand;
    addend  = digit.neg ? ~addend_mag : addend_mag;
    acc_sum = acc + addend + AW'(digit.neg);
  end

  // Next-state logic and handshake outputs, all decoded from the state register.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
    accept     = in_valid && (state == IDLE);
    last       = (state == CALC) && (count == CW'(ITER - 1));
    case (state)
      IDLE: if (accept) state_next = zero_op ? DONE : CALC;
      CALC: if (last)   state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Datapath: latch operands on accept, then shift and accumulate one digit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      count <= '0;
      p_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= {{(AW-EW){x_ext[EW-1]}}, x_ext};
            mult  <= {y_ext, 1'b0};
            acc   <= '0;
            count <= '0;
            if (zero_op) p_reg <= '0;
          end
        end
        CALC: begin
          acc   <= acc_sum;
          mcand <= {mcand[AW-3:0], 2'b00};
          mult  <= {2'b00, mult[EW:2]};
          count <= count + CW'(1);
          if (last) p_reg <= acc_sum[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign p = p_reg;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed self-checking bench for booth_seq_multiplier at WIDTH=16.
module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int checks;
  int passes;

  booth_seq_multiplier #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation; lat counts rising edges after the accept edge until out_valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input bit hold, output int lat, output logic [31:0] prod,
                        output bit timed_out);
    @(negedge clk);
    x = a; y = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~a; y = ~b; in_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = p;
    timed_out = !out_valid;
    if (!hold) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; x = '0; y = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (p !== 32'h0) $display("[TB] FAIL reset_p: got %h expected 00000000", p); else passes++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_signed_small();
    int lat; logic [31:0] prod; bit to;
    run_op(16'h0003, 16'hFFFB, 1'b1, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'hFFFFFFF1) $display("[TB] FAIL mul_3_neg5: got %h expected fffffff1", prod); else passes++;
    checks++; if (lat !== 9) $display("[TB] FAIL latency_nonzero: got %0d expected 9", lat); else passes++;
  endtask

  task automatic test_extremes();
    int lat; logic [31:0] prod; bit to;
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'h40000000) $display("[TB] FAIL signed_min_sq: got %h expected 40000000", prod); else passes++;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'hFFFE0001) $display("[TB] FAIL unsigned_max_sq: got %h expected fffe0001", prod); else passes++;
    checks++; if (lat !== 9) $display("[TB] FAIL latency_unsigned: got %0d expected 9", lat); else passes++;
  endtask

  task automatic test_zero_skip();
    int lat; logic [31:0] prod; bit to;
    run_op(16'h1234, 16'h0000, 1'b1, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'h0) $display("[TB] FAIL zero_skip_p: got %h expected 00000000", prod); else passes++;
    // Zero skip: out_valid is already up in the cycle right after the accept edge.
    checks++; if (lat !== 0) $display("[TB] FAIL zero_skip_latency: got %0d expected 0", lat); else passes++;
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'hFFFFFFFF) $display("[TB] FAIL neg1_times_1: got %h expected ffffffff", prod); else passes++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] prod; bit to;
    run_op(16'd100, 16'd200, 1'b0, 1'b1, lat, prod, to);
    checks++; if (to || prod !== 32'h00004E20) $display("[TB] FAIL bp_product: got %h expected 00004e20", prod); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0]; x = 16'h5555; y = 16'h3333; in_signed = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== 32'h00004E20)
        $display("[TB] FAIL bp_hold_%0d: got valid=%b ready=%b p=%h expected valid=1 ready=0 p=00004e20", i, out_valid, in_ready, p);
      else passes++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL bp_release: got ready=%b valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    else passes++;
    run_op(16'd2, 16'd3, 1'b0, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'd6) $display("[TB] FAIL bp_after: got %h expected 00000006", prod); else passes++;
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [31:0] prod; bit to;
    @(negedge clk);
    x = 16'd9; y = 16'd9; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || p !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL mid_reset: got valid=%b p=%h ready=%b busy=%b expected 0 00000000 1 0", out_valid, p, in_ready, busy);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_no_valid: got %b expected 0", out_valid); else passes++;
    end
    run_op(16'd7, 16'd6, 1'b0, 1'b0, lat, prod, to);
    checks++; if (to || prod !== 32'd42) $display("[TB] FAIL after_reset_7x6: got %h expected 0000002a", prod); else passes++;
    checks++; if (lat !== 9) $display("[TB] FAIL after_reset_latency: got %0d expected 9", lat); else passes++;
  endtask

  task automatic test_random();
    int lat; logic [31:0] prod; bit to;
    logic [15:0] a, b; logic s;
    int sa, sb; longint ua, ub; logic [31:0] exp_p;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      if (i % 17 == 0) a = 16'h0;
      sa = int'($signed(a)); sb = int'($signed(b));
      ua = longint'(a); ub = longint'(b);
      exp_p = s ? 32'(sa * sb) : 32'(ua * ub);
      run_op(a, b, s, 1'b0, lat, prod, to);
      checks++;
      if (to || prod !== exp_p)
        $display("[TB] FAIL random_%0d: %h*%h s=%b got %h expected %h", i, a, b, s, prod, exp_p);
      else passes++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    test_reset();
    test_signed_small();
    test_extremes();
    test_zero_skip();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
